// File: rtl/lfsr_rng_arbiter_pkg.sv
// Shared FSM encodings, default LFSR constants and the round-robin pick for lfsr_rng_arbiter.
// Build option: LFSR_LOCKUP_GUARD_EN (zero-seed substitution and sticky lockup flag).
package lfsr_rng_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  localparam int         LFSR_W   = 8;
  localparam logic [7:0] DEF_TAPS = 8'b1011_1000;  // x^8+x^6+x^5+x^4+1
  localparam logic [7:0] DEF_SEED = 8'h01;

  // With both requesting, the requester that did not win last time goes next.
  function automatic logic pick_winner(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

endpackage

// File: rtl/lfsr_rng_arbiter_if.sv
// Request/word-delivery bundle between the random-byte consumers and lfsr_rng_arbiter.
// Build option: LFSR_LOCKUP_GUARD_EN only affects the meaning of lockup.
interface lfsr_rng_arbiter_if #(
  parameter int WIDTH = 8
) ();

  logic             seed_load;
  logic [WIDTH-1:0] seed_val;
  logic [1:0]       req;
  logic [1:0]       out_ack;
  logic [1:0]       gnt;
  logic [1:0]       out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             lockup;

  modport master (
    output seed_load, seed_val, req, out_ack,
    input  gnt, out_valid, out_data, busy, lockup
  );

  modport slave (
    input  seed_load, seed_val, req, out_ack,
    output gnt, out_valid, out_data, busy, lockup
  );

endinterface

// File: rtl/lfsr_rng_arbiter_core.sv
// Fibonacci LFSR register with load and step enable; load beats step.
// Build option LFSR_LOCKUP_GUARD_EN is handled by the parent, not here.
module lfsr_rng_arbiter_core
  import lfsr_rng_arbiter_pkg::*;
#(
  parameter int               WIDTH        = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS         = DEF_TAPS,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_en,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DEFAULT_SEED;
    end else if (load) begin
      state <= load_val;
    end else if (step_en) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Two-requester round-robin random-byte service built around one shared LFSR.
// Build option: define LFSR_LOCKUP_GUARD_EN to replace zero seeds and flag them on lockup.
module lfsr_rng_arbiter
  import lfsr_rng_arbiter_pkg::*;
#(
  parameter int               WIDTH        = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS         = DEF_TAPS,
  parameter int               STEPS        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = DEF_SEED
) (
  input logic               clk,
  input logic               rst,
  lfsr_rng_arbiter_if.slave bus
);

  localparam int               CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             winner;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic [WIDTH-1:0] seed_eff;

  assign winner = pick_winner(bus.req, last);

`ifdef LFSR_LOCKUP_GUARD_EN
  logic zero_seed;
  assign zero_seed = (bus.seed_val == '0);
  assign seed_eff  = zero_seed ? DEFAULT_SEED : bus.seed_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.lockup <= 1'b0;
    end else if (bus.seed_load && zero_seed) begin
      bus.lockup <= 1'b1;
    end
  end
`else
  // A zero seed goes in verbatim and parks the LFSR at zero.
  assign seed_eff   = bus.seed_val;
  assign bus.lockup = 1'b0;
`endif

  lfsr_rng_arbiter_core #(
    .WIDTH       (WIDTH),
    .TAPS        (TAPS),
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (bus.seed_load),
    .load_val  (seed_eff),
    .step_en   (state == ST_SHIFT),
    .state     (lfsr_q),
    .next_state(lfsr_d)
  );

  // Seed load overrides everything, including a same-cycle ack; rr pointer is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      last          <= 1'b1;
      bus.gnt       <= 2'b00;
      bus.out_valid <= 2'b00;
      bus.out_data  <= '0;
      bus.busy      <= 1'b0;
    end else if (bus.seed_load) begin
      state         <= ST_IDLE;
      bus.gnt       <= 2'b00;
      bus.out_valid <= 2'b00;
      bus.busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            bus.gnt  <= winner ? 2'b10 : 2'b01;
            last     <= winner;
            cnt      <= CNT_LOAD;
            state    <= ST_SHIFT;
            bus.busy <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt == '0) begin
            bus.out_data  <= lfsr_d;
            bus.out_valid <= bus.gnt;
            state         <= ST_PRESENT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PRESENT: begin
          if (|(bus.out_ack & bus.gnt)) begin
            bus.gnt       <= 2'b00;
            bus.out_valid <= 2'b00;
            bus.busy      <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state         <= ST_IDLE;
          bus.gnt       <= 2'b00;
          bus.out_valid <= 2'b00;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Scoreboard bench for lfsr_rng_arbiter: directed stimulus pushes expected words, a monitor pops them.
// Honours LFSR_LOCKUP_GUARD_EN for the zero-seed expectations.
module tb_lfsr_rng_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [8:0] sb_q[$];  // {requester index, expected word}

  always #5 clk = ~clk;

  lfsr_rng_arbiter_if #(.WIDTH(8)) bus ();

  lfsr_rng_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each fresh presentation is matched against the oldest expectation.
  initial begin
    logic [1:0] prev;
    logic [8:0] e;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid != 2'b00 && prev == 2'b00) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", bus.out_data);
        end else begin
          e = sb_q.pop_front();
          chk("word_index", {30'd0, bus.out_valid}, e[8] ? 32'd2 : 32'd1);
          chk("word_data", {24'd0, bus.out_data}, {24'd0, e[7:0]});
        end
      end
      prev = rst ? 2'b00 : bus.out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int start);
    int n;
    n = start;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid != 2'b00) break;
      tick();
      n++;
    end
    chk("valid_latency", n, 9);
  endtask

  task automatic ack_word(input logic [1:0] oh);
    bus.out_ack = oh;
    tick();
    bus.out_ack = 2'b00;
    chk("ack_gnt_clear", {30'd0, bus.gnt}, 0);
    chk("ack_valid_clear", {30'd0, bus.out_valid}, 0);
  endtask

  task automatic do_reset();
    bus.req = 2'b00;
    bus.out_ack = 2'b00;
    bus.seed_load = 1'b0;
    bus.seed_val = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values and two single-requester words
    do_reset();
    chk("rst_gnt", {30'd0, bus.gnt}, 0);
    chk("rst_valid", {30'd0, bus.out_valid}, 0);
    chk("rst_data", {24'd0, bus.out_data}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_lockup", {31'd0, bus.lockup}, 0);
    sb_q.push_back({1'b0, 8'h1C});
    bus.req = 2'b01;
    tick();
    chk("gnt_after_1", {30'd0, bus.gnt}, 1);
    chk("busy_shift", {31'd0, bus.busy}, 1);
    bus.req = 2'b00;
    wait_valid(1);
    chk("gnt_held", {30'd0, bus.gnt}, 1);
    ack_word(2'b01);
    chk("idle_busy", {31'd0, bus.busy}, 0);
    sb_q.push_back({1'b0, 8'h4B});
    bus.req = 2'b01;
    wait_valid(0);
    bus.req = 2'b00;
    ack_word(2'b01);

    // Both requesting: grants alternate
    do_reset();
    sb_q.push_back({1'b0, 8'h1C});
    sb_q.push_back({1'b1, 8'h4B});
    sb_q.push_back({1'b0, 8'h81});
    sb_q.push_back({1'b1, 8'h92});
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_valid(0);
      chk("rr_gnt", {30'd0, bus.gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
      ack_word((k % 2 == 0) ? 2'b01 : 2'b10);
    end
    bus.req = 2'b00;

    // Held word, wrong-index ack ignored, LFSR frozen
    do_reset();
    sb_q.push_back({1'b0, 8'h1C});
    bus.req = 2'b01;
    wait_valid(0);
    bus.req = 2'b00;
    for (int k = 0; k < 20; k++) begin
      bus.out_ack = 2'b10;
      tick();
      chk("hold_data", {24'd0, bus.out_data}, 32'h1C);
      chk("hold_gnt", {30'd0, bus.gnt}, 1);
    end
    bus.out_ack = 2'b00;
    chk("hold_valid", {30'd0, bus.out_valid}, 1);
    ack_word(2'b01);
    sb_q.push_back({1'b0, 8'h4B});
    bus.req = 2'b01;
    wait_valid(0);
    bus.req = 2'b00;
    ack_word(2'b01);

    // Seed load during SHIFT aborts; rr pointer keeps requester 0 as last winner
    do_reset();
    bus.req = 2'b01;
    tick();
    bus.req = 2'b00;
    tick();
    tick();
    chk("abort_pre_busy", {31'd0, bus.busy}, 1);
    bus.seed_load = 1'b1;
    bus.seed_val = 8'h01;
    tick();
    bus.seed_load = 1'b0;
    chk("abort_gnt", {30'd0, bus.gnt}, 0);
    chk("abort_valid", {30'd0, bus.out_valid}, 0);
    chk("abort_busy", {31'd0, bus.busy}, 0);
    sb_q.push_back({1'b1, 8'h1C});
    bus.req = 2'b11;
    wait_valid(0);
    bus.req = 2'b00;
    chk("abort_rr_gnt", {30'd0, bus.gnt}, 2);
    ack_word(2'b10);

    // Zero seed
    do_reset();
    bus.seed_load = 1'b1;
    bus.seed_val = 8'h00;
    tick();
    bus.seed_load = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
    chk("lockup_set", {31'd0, bus.lockup}, 1);
    sb_q.push_back({1'b0, 8'h1C});
`else
    chk("lockup_tied", {31'd0, bus.lockup}, 0);
    sb_q.push_back({1'b0, 8'h00});
`endif
    bus.req = 2'b01;
    wait_valid(0);
    bus.req = 2'b00;
    ack_word(2'b01);
`ifdef LFSR_LOCKUP_GUARD_EN
    chk("lockup_sticky", {31'd0, bus.lockup}, 1);
`else
    chk("lockup_still0", {31'd0, bus.lockup}, 0);
`endif

    // Async reset between edges mid-SHIFT
    do_reset();
    bus.req = 2'b01;
    tick();
    bus.req = 2'b00;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    chk("async_gnt", {30'd0, bus.gnt}, 0);
    chk("async_busy", {31'd0, bus.busy}, 0);
    chk("async_valid", {30'd0, bus.out_valid}, 0);
    #1 rst = 1'b0;
    sb_q.push_back({1'b0, 8'h1C});
    bus.req = 2'b01;
    wait_valid(0);
    bus.req = 2'b00;
    ack_word(2'b01);

    tick();
    tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
